// File: rtl/cgra_im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: header field layout,
// end-marker target code, FSM state encoding and target classification.
package cgra_im_loader_pkg;

   // Target code that terminates the load stream instead of opening a record
   localparam logic [7:0] TARGET_END = 8'hFF;

   // Header word field positions
   localparam int TGT_LSB = 0;
   localparam int CNT_LSB = 16;

   typedef enum logic [1:0] {
      HDR0    = 2'd0,
      ADDR    = 2'd1,
      DATA_LO = 2'd2,
      DATA_HI = 2'd3
   } state_e;

   // How the payload of the current record is interpreted
   typedef enum logic [1:0] {
      KIND_ID  = 2'd0,
      KIND_IMM = 2'd1,
      KIND_BAD = 2'd2
   } kind_e;

endpackage

// File: rtl/cgra_im_loader_if.sv
// Host-to-loader word stream: 32-bit words qualified by iValid, accepted on iValid & oReady.
// The loader side is the slave; the host/configuration bus is the master.
// Signal names follow the loader's external port names.
interface cgra_im_loader_if #(
   parameter int IN_WIDTH = 32
) ();

   logic [IN_WIDTH-1:0] iData;
   logic                iValid;
   logic                oReady;

   modport master (
      output iData,
      output iValid,
      input  oReady
   );

   modport slave (
      input  iData,
      input  iValid,
      output oReady
   );

endinterface

// File: rtl/cgra_im_loader.sv
// Parses load records from a word stream and writes decoder/immediate IMs one instruction at a time.
// Latency: write strobe, address and data appear one cycle after an instruction's final word.
// Backpressure: none internally; oReady is high whenever out of reset, iValid gaps stall the parser.
module cgra_im_loader
   import cgra_im_loader_pkg::*;
#(
   parameter int I_WIDTH           = 12,
   parameter int I_IMM_WIDTH       = 33,
   parameter int IM_MEM_ADDR_WIDTH = 8,
   parameter int NUM_ID            = 6,
   parameter int NUM_IMM           = 3,
   parameter int IN_WIDTH          = 32
) (
   input  logic                         iClk,
   input  logic                         iReset,
   cgra_im_loader_if.slave              s_if,
   output logic [NUM_ID+NUM_IMM-1:0]    oIM_WriteEnable,
   output logic [IM_MEM_ADDR_WIDTH-1:0] oIM_WriteAddress,
   output logic [I_WIDTH-1:0]           oIM_WriteData,
   output logic [I_IMM_WIDTH-1:0]       oIM_WriteData_IMM,
   output logic                         oBusy,
   output logic                         oDone,
   output logic                         oError
);

   localparam int NUM_T = NUM_ID + NUM_IMM;
   localparam int AW    = IM_MEM_ADDR_WIDTH;

   state_e               state_q, state_d;
   kind_e                kind_q, kind_d;
   logic [7:0]           tgt_q, tgt_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [31:0]          lo_q, lo_d;
   logic [NUM_T-1:0]     we_q, we_d;
   logic [AW-1:0]        wa_q, wa_d;
   logic [I_WIDTH-1:0]   wd_q, wd_d;
   logic [I_IMM_WIDTH-1:0] wdi_q, wdi_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic [IN_WIDTH-1:0]  word;
   logic                 accept;
   logic [7:0]           hdr_tgt;
   logic [15:0]          hdr_cnt;

   assign word    = s_if.iData;
   assign accept  = s_if.iValid & ready_q;
   assign hdr_tgt = word[TGT_LSB +: 8];
   assign hdr_cnt = word[CNT_LSB +: 16];

   // Next-state: header parsing, instruction assembly and write-strobe generation
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      lo_d    = lo_q;
      we_d    = '0;
      wa_d    = wa_q;
      wd_d    = wd_q;
      wdi_d   = wdi_q;
      ready_d = 1'b1;
      done_d  = done_q;
      err_d   = err_q;
      if (accept) begin
         case (state_q)
            HDR0: begin
               done_d = 1'b0;
               tgt_d  = hdr_tgt;
               cnt_d  = hdr_cnt;
               if (hdr_tgt == TARGET_END) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ADDR;
                  if (hdr_tgt < 8'(NUM_ID)) begin
                     kind_d = KIND_ID;
                  end else if (hdr_tgt < 8'(NUM_T)) begin
                     kind_d = KIND_IMM;
                  end else begin
                     // Unknown target: payload is still drained one word per instruction
                     kind_d = KIND_BAD;
                     err_d  = 1'b1;
                  end
               end
            end
            ADDR: begin
               addr_d  = word[AW-1:0];
               state_d = (cnt_q == 16'd0) ? HDR0 : DATA_LO;
            end
            DATA_LO: begin
               if (kind_q == KIND_IMM) begin
                  lo_d    = word[31:0];
                  state_d = DATA_HI;
               end else begin
                  if (kind_q == KIND_ID) begin
                     we_d = NUM_T'(1) << tgt_q;
                     wa_d = addr_q;
                     wd_d = word[I_WIDTH-1:0];
                  end
                  addr_d  = addr_q + AW'(1);
                  cnt_d   = cnt_q - 16'd1;
                  state_d = (cnt_q == 16'd1) ? HDR0 : DATA_LO;
               end
            end
            DATA_HI: begin
               we_d    = NUM_T'(1) << tgt_q;
               wa_d    = addr_q;
               wdi_d   = {word[I_IMM_WIDTH-33:0], lo_q};
               addr_d  = addr_q + AW'(1);
               cnt_d   = cnt_q - 16'd1;
               state_d = (cnt_q == 16'd1) ? HDR0 : DATA_LO;
            end
            default: state_d = HDR0;
         endcase
      end
      busy_d = (state_d != HDR0);
   end

   // State and registered outputs; reset drops any partially received record
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q <= HDR0;
         kind_q  <= KIND_ID;
         tgt_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         lo_q    <= '0;
         we_q    <= '0;
         wa_q    <= '0;
         wd_q    <= '0;
         wdi_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         lo_q    <= lo_d;
         we_q    <= we_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         wdi_q   <= wdi_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign s_if.oReady       = ready_q;
   assign oIM_WriteEnable   = we_q;
   assign oIM_WriteAddress  = wa_q;
   assign oIM_WriteData     = wd_q;
   assign oIM_WriteData_IMM = wdi_q;
   assign oBusy             = busy_q;
   assign oDone             = done_q;
   assign oError            = err_q;

endmodule

// File: tb/tb_cgra_im_loader.sv
// Self-checking bench for cgra_im_loader: records are expanded into per-word expectations
// by a record-level model, played with optional random iValid gaps, and every output is
// compared on each falling clock edge; observed writes are logged for literal spot checks.
module tb_cgra_im_loader;
   import cgra_im_loader_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cgra_im_loader_if #(.IN_WIDTH(32)) s_if ();

   logic [8:0]  oIM_WriteEnable;
   logic [7:0]  oIM_WriteAddress;
   logic [11:0] oIM_WriteData;
   logic [32:0] oIM_WriteData_IMM;
   logic        oBusy, oDone, oError;

   cgra_im_loader #(
      .I_WIDTH(12), .I_IMM_WIDTH(33), .IM_MEM_ADDR_WIDTH(8),
      .NUM_ID(6), .NUM_IMM(3), .IN_WIDTH(32)
   ) dut (
      .iClk(clk),
      .iReset(rst),
      .s_if(s_if.slave),
      .oIM_WriteEnable(oIM_WriteEnable),
      .oIM_WriteAddress(oIM_WriteAddress),
      .oIM_WriteData(oIM_WriteData),
      .oIM_WriteData_IMM(oIM_WriteData_IMM),
      .oBusy(oBusy),
      .oDone(oDone),
      .oError(oError)
   );

   // One stream word plus what the loader must show after accepting it
   typedef struct {
      logic [31:0] w;
      bit          wr;
      bit          imm;
      logic [8:0]  we;
      logic [7:0]  addr;
      logic [11:0] d;
      logic [32:0] di;
      bit          busy;
      bit          done;
      bit          err;
   } tag_t;

   typedef struct {
      logic [8:0]  we;
      logic [7:0]  wa;
      logic [11:0] wd;
      logic [32:0] wdi;
   } wr_t;

   tag_t        wq[$];
   tag_t        saved[$];
   tag_t        idle_t;
   logic [31:0] pl[$];
   wr_t         wlog[$];
   wr_t         glog[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;
   bit m_done, m_err;

   logic [8:0]  exp_we;
   logic [7:0]  exp_wa;
   logic [11:0] exp_wd;
   logic [32:0] exp_wdi;
   bit exp_ready, exp_busy, exp_done, exp_err;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   // Per-cycle comparison of every output against the model expectation
   always @(negedge clk) begin
      if (chk_en) begin
         chk("we",    64'(oIM_WriteEnable),   64'(exp_we));
         chk("addr",  64'(oIM_WriteAddress),  64'(exp_wa));
         chk("wd",    64'(oIM_WriteData),     64'(exp_wd));
         chk("wdi",   64'(oIM_WriteData_IMM), 64'(exp_wdi));
         chk("ready", 64'(s_if.oReady),       64'(exp_ready));
         chk("busy",  64'(oBusy),             64'(exp_busy));
         chk("done",  64'(oDone),             64'(exp_done));
         chk("err",   64'(oError),            64'(exp_err));
         if (oIM_WriteEnable != '0)
            wlog.push_back('{oIM_WriteEnable, oIM_WriteAddress, oIM_WriteData, oIM_WriteData_IMM});
      end
   end

   // One clock cycle of stimulus and the expectation it implies
   task automatic tick(input bit r, input bit v, input tag_t t);
      bit acc;
      rst = r;
      s_if.iValid = v;
      s_if.iData  = v ? t.w : $urandom;
      acc = v && !r && exp_ready;
      @(posedge clk);
      if (r) begin
         exp_ready = 0; exp_we = '0; exp_wa = '0; exp_wd = '0; exp_wdi = '0;
         exp_busy = 0; exp_done = 0; exp_err = 0;
      end else begin
         exp_ready = 1;
         exp_we = '0;
         if (acc) begin
            exp_busy = t.busy;
            exp_done = t.done;
            exp_err  = t.err;
            if (t.wr) begin
               exp_we = t.we;
               exp_wa = t.addr;
               if (t.imm) exp_wdi = t.di;
               else       exp_wd  = t.d;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'($urandom), idle_t);
      m_done = 0;
      m_err  = 0;
      tick(1'b0, 1'b0, idle_t);
   endtask

   // Record-level model: expands one record into its stream words and expected effects
   task automatic add_rec(input logic [7:0] t, input int n, input logic [7:0] a);
      tag_t g;
      bit imm, good, last;
      int wpi;
      logic [31:0] lo;
      lo = '0;
      g = idle_t;
      g.w = {n[15:0], 8'($urandom), t};
      if (t == TARGET_END) begin
         m_done = 1;
         g.done = 1; g.err = m_err; g.busy = 0;
         wq.push_back(g);
         return;
      end
      m_done = 0;
      imm  = (t >= 8'd6) && (t < 8'd9);
      good = (t < 8'd9);
      if (!good) m_err = 1;
      g.busy = 1; g.done = 0; g.err = m_err;
      wq.push_back(g);
      g = idle_t;
      g.w = {24'($urandom), a};
      g.busy = (n != 0); g.err = m_err;
      wq.push_back(g);
      wpi = imm ? 2 : 1;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < wpi; j++) begin
            g = idle_t;
            g.w = pl.pop_front();
            g.err = m_err;
            last = (j == wpi - 1);
            g.busy = !(last && (i == n - 1));
            if (!last) lo = g.w;
            if (last && good) begin
               g.wr   = 1;
               g.imm  = imm;
               g.we   = 9'(1) << t;
               g.addr = a + 8'(i);
               g.d    = g.w[11:0];
               g.di   = {g.w[0], lo};
            end
            wq.push_back(g);
         end
      end
   endtask

   task automatic fill(input int k);
      for (int i = 0; i < k; i++) pl.push_back($urandom);
   endtask

   task automatic play(input bit gaps);
      while (wq.size() > 0) begin
         if (gaps && $urandom_range(0, 2) == 0) tick(1'b0, 1'b0, idle_t);
         else tick(1'b0, 1'b1, wq.pop_front());
      end
      tick(1'b0, 1'b0, idle_t);
      tick(1'b0, 1'b0, idle_t);
   endtask

   task automatic chk_log(input string nm, input int i, input logic [8:0] we,
                          input logic [7:0] wa, input logic [32:0] dat, input bit imm);
      if (i >= wlog.size()) begin
         chk({nm, " missing"}, 64'(wlog.size()), 64'(i + 1));
         return;
      end
      chk({nm, " we"},   64'(wlog[i].we), 64'(we));
      chk({nm, " addr"}, 64'(wlog[i].wa), 64'(wa));
      if (imm) chk({nm, " wdi"}, 64'(wlog[i].wdi), 64'(dat));
      else     chk({nm, " wd"},  64'(wlog[i].wd),  64'(dat));
   endtask

   initial begin
      idle_t = '{default: '0};
      rst = 1'b1;
      s_if.iValid = 1'b0;
      s_if.iData  = '0;
      chk_en = 1'b1;
      do_reset(3);

      // ID target, three single-word instructions
      wlog.delete();
      pl = '{32'h0000_0ABC, 32'hFFFF_F123, 32'h0000_0456};
      add_rec(8'd2, 3, 8'h10);
      play(1'b0);
      chk("t1 count", 64'(wlog.size()), 64'd3);
      chk_log("t1 w0", 0, 9'b000000100, 8'h10, 33'h0ABC, 1'b0);
      chk_log("t1 w1", 1, 9'b000000100, 8'h11, 33'h0123, 1'b0);
      chk_log("t1 w2", 2, 9'b000000100, 8'h12, 33'h0456, 1'b0);

      // IMM target, two-word instruction
      wlog.delete();
      pl = '{32'hDEAD_BEEF, 32'hFFFF_FFF1};
      add_rec(8'd7, 1, 8'h05);
      play(1'b0);
      chk("t2 count", 64'(wlog.size()), 64'd1);
      chk_log("t2 w0", 0, 9'b010000000, 8'h05, 33'h1DEADBEEF, 1'b1);

      // Address wrap
      wlog.delete();
      fill(2);
      add_rec(8'd0, 2, 8'hFF);
      play(1'b0);
      chk("t3 count", 64'(wlog.size()), 64'd2);
      if (wlog.size() == 2) begin
         chk("t3 a0", 64'(wlog[0].wa), 64'h0FF);
         chk("t3 a1", 64'(wlog[1].wa), 64'h000);
      end

      // Invalid target drained, then a valid record
      wlog.delete();
      fill(2);
      add_rec(8'd12, 2, 8'h33);
      pl = '{32'h0000_0777};
      add_rec(8'd1, 1, 8'h40);
      play(1'b0);
      chk("t4 error", 64'(oError), 64'd1);
      chk("t4 count", 64'(wlog.size()), 64'd1);
      chk_log("t4 w0", 0, 9'b000000010, 8'h40, 33'h0777, 1'b0);

      // Empty record
      wlog.delete();
      add_rec(8'd3, 0, 8'h50);
      play(1'b0);
      chk("t5 count", 64'(wlog.size()), 64'd0);

      // Same record gapless and with random gaps, then end marker
      wlog.delete();
      fill(6);
      add_rec(8'd8, 3, 8'h7E);
      saved = wq;
      play(1'b0);
      glog = wlog;
      wlog.delete();
      wq = saved;
      play(1'b1);
      chk("t6 count", 64'(wlog.size()), 64'(glog.size()));
      for (int i = 0; i < wlog.size() && i < glog.size(); i++) begin
         chk("t6 we",  64'(wlog[i].we),  64'(glog[i].we));
         chk("t6 wa",  64'(wlog[i].wa),  64'(glog[i].wa));
         chk("t6 wdi", 64'(wlog[i].wdi), 64'(glog[i].wdi));
      end
      add_rec(TARGET_END, 0, 8'h00);
      play(1'b1);
      chk("t6 done", 64'(oDone), 64'd1);

      // Random records with gaps
      for (int r = 0; r < 30; r++) begin
         int sel, n;
         logic [7:0] t;
         sel = $urandom_range(0, 9);
         if (sel < 7)       t = 8'($urandom_range(0, 8));
         else if (sel < 9)  t = 8'($urandom_range(9, 254));
         else               t = TARGET_END;
         n = $urandom_range(0, 4);
         if (t != TARGET_END) fill(((t >= 8'd6) && (t < 8'd9)) ? 2 * n : n);
         add_rec(t, n, 8'($urandom));
         play(1'b1);
      end

      // Reset after the low word of an IMM instruction
      do_reset(2);
      wlog.delete();
      pl = '{32'h1234_5678, 32'h0000_0001};
      add_rec(8'd7, 1, 8'h20);
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, wq.pop_front());
      wq.delete();
      do_reset(2);
      tick(1'b0, 1'b0, idle_t);
      chk("t8 no write", 64'(wlog.size()), 64'd0);
      pl = '{32'h0000_0555};
      add_rec(8'd4, 1, 8'h60);
      play(1'b1);
      chk_log("t8 w0", 0, 9'b000010000, 8'h60, 33'h0555, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
